// File: rtl/flow_fifo.sv
// flow_fifo: receive-path FIFO with hysteretic RTS flow control, occupancy
// output, synchronous flush and sticky overflow reporting.
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// Optional feature macro: FLOW_FIFO_STATS_EN enables a saturating 16-bit
// rejected-beat counter on drop_count_o (tied to zero when undefined).
module flow_fifo #(
    parameter int unsigned Width    = 8,
    parameter int unsigned Depth    = 16,
    parameter int unsigned HighMark = 12,
    parameter int unsigned LowMark  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [Width-1:0]       data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [Width-1:0]       data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   rts_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   overflow_o,
    output logic [15:0]            drop_count_o
);

    localparam int unsigned AddrWidth = $clog2(Depth);
    localparam int unsigned CntWidth  = AddrWidth + 1;

    // Reject illegal configurations at elaboration time
    if ((Depth < 4) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
        $error("flow_fifo: Depth must be a power of two and at least 4");
    end
    if (!((LowMark < HighMark) && (HighMark <= Depth))) begin : g_bad_marks
        $error("flow_fifo: require LowMark < HighMark <= Depth");
    end

    typedef enum logic {
        FLOW = 1'b0,
        STOP = 1'b1
    } rts_state_e;

    logic [Width-1:0]     mem [Depth];
    logic [CntWidth-1:0]  wr_ptr_q;
    logic [CntWidth-1:0]  rd_ptr_q;
    logic [CntWidth-1:0]  count_q;
    logic [CntWidth-1:0]  count_d;
    logic                 ready_q;
    logic                 valid_q;
    logic [Width-1:0]     head_q;
    logic [Width-1:0]     head_d;
    logic                 head_load;
    logic                 overflow_q;
    rts_state_e           rts_q;

    logic                 push;
    logic                 pop;
    logic                 reject;
    logic [AddrWidth-1:0] wr_addr;
    logic [AddrWidth-1:0] rd_next_addr;

    // Handshakes use registered ready/valid only; clear wins over both
    assign push   = valid_i && ready_q && !clear_i;
    assign pop    = valid_q && ready_i && !clear_i;
    assign reject = valid_i && !ready_q;

    assign wr_addr      = wr_ptr_q[AddrWidth-1:0];
    assign rd_next_addr = AddrWidth'(rd_ptr_q + CntWidth'(1));

    // Next occupancy, shared by the status flops and the RTS machine
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CntWidth'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    // Head register refill: bypass from data_i when the head is (about to be)
    // empty, otherwise prefetch the next RAM entry after a pop
    always_comb begin
        head_load = 1'b0;
        head_d    = head_q;
        if (push && ((count_q == '0) || ((count_q == CntWidth'(1)) && pop))) begin
            head_load = 1'b1;
            head_d    = data_i;
        end else if (pop && (count_q > CntWidth'(1))) begin
            head_load = 1'b1;
            head_d    = mem[rd_next_addr];
        end
    end

    // Storage array; every accepted beat is written, the head keeps a copy
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_addr] <= data_i;
        end
    end

    // Pointers, occupancy and decoded ready/valid flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            if (clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + CntWidth'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + CntWidth'(1);
                end
            end
            count_q <= count_d;
            ready_q <= (count_d != CntWidth'(Depth));
            valid_q <= (count_d != '0);
        end
    end

    // Output head register; holds while the consumer stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
        end else if (head_load) begin
            head_q <= head_d;
        end
    end

    // Hysteretic RTS: assert at the high mark, release only at the low mark
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rts_q <= FLOW;
        end else if (clear_i) begin
            rts_q <= FLOW;
        end else begin
            case (rts_q)
                FLOW: begin
                    if (count_d >= CntWidth'(HighMark)) begin
                        rts_q <= STOP;
                    end
                end
                STOP: begin
                    if (count_d <= CntWidth'(LowMark)) begin
                        rts_q <= FLOW;
                    end
                end
                default: rts_q <= FLOW;
            endcase
        end
    end

    // Sticky overflow flag; the offending beat is simply dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            overflow_q <= 1'b0;
        end else if (reject) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef FLOW_FIFO_STATS_EN
    logic [15:0] drop_q;

    // Saturating count of rejected beats
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= '0;
        end else if (clear_i) begin
            drop_q <= '0;
        end else if (reject && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count_o = drop_q;
`else
    assign drop_count_o = 16'h0000;
`endif

    assign ready_o    = ready_q;
    assign valid_o    = valid_q;
    assign data_o     = head_q;
    assign count_o    = count_q;
    assign rts_o      = (rts_q == STOP);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_flow_fifo.sv
// tb_flow_fifo: table vectors, hand-written corner sequences and a data
// scoreboard for flow_fifo at default parameters.
module tb_flow_fifo;

    localparam int D  = 16;
    localparam int HM = 12;
    localparam int LM = 8;
`ifdef FLOW_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk_i   = 1'b0;
    logic        rst_ni  = 1'b0;
    logic        clear_i = 1'b0;
    logic [7:0]  data_i  = 8'h00;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        ready_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        rts_o;
    logic [4:0]  count_o;
    logic        overflow_o;
    logic [15:0] drop_count_o;

    flow_fifo dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .rts_o        (rts_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .drop_count_o (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         r;
        int         e_cnt;
        bit         e_rts;
        bit         e_rdy;
        bit         e_ovf;
    } vec_t;

    vec_t       tbl [17];
    logic [7:0] sb_q [$];
    int         m_cnt;
    bit         m_rts;
    bit         m_ovf;
    int         m_drop;
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_cnt  = 0;
        m_rts  = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count_o), 32'(m_cnt));
        chk({tag, ".valid"}, 32'(valid_o), 32'(m_cnt != 0));
        chk({tag, ".ready"}, 32'(ready_o), 32'(m_cnt != D));
        chk({tag, ".rts"}, 32'(rts_o), 32'(m_rts));
        chk({tag, ".ovf"}, 32'(overflow_o), 32'(m_ovf));
        chk({tag, ".drop"}, 32'(drop_count_o), 32'(m_drop));
    endtask

    // One clock: drive, predict, check popped data, advance, check status
    task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit clr);
        bit         m_push;
        bit         m_pop;
        bit         m_rej;
        logic [7:0] e;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        clear_i = clr;
        m_push  = v && (m_cnt != D) && !clr;
        m_pop   = (m_cnt != 0) && r && !clr;
        m_rej   = v && (m_cnt == D);
        #1;
        if (m_pop) begin
            e = sb_q.pop_front();
            chk("data_o", 32'(data_o), 32'(e));
        end
        if (clr) begin
            model_reset();
        end else begin
            if (m_push) sb_q.push_back(d);
            if (m_push && !m_pop) m_cnt++;
            if (m_pop && !m_push) m_cnt--;
            if (m_rej) begin
                m_ovf = 1'b1;
                if (STATS && m_drop < 65535) m_drop++;
            end
            if (!m_rts && m_cnt >= HM) m_rts = 1'b1;
            else if (m_rts && m_cnt <= LM) m_rts = 1'b0;
        end
        @(posedge clk_i);
        #1;
        check_state("cyc");
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_pushed;
        bit v;
        bit r;

        // Fill table: 16 pushes with consumer stalled, then one rejected beat
        for (int i = 0; i < 16; i++) begin
            tbl[i].v     = 1'b1;
            tbl[i].d     = 8'(i + 1);
            tbl[i].r     = 1'b0;
            tbl[i].e_cnt = i + 1;
            tbl[i].e_rts = (i + 1 >= HM);
            tbl[i].e_rdy = (i + 1 != D);
            tbl[i].e_ovf = 1'b0;
        end
        tbl[16].v     = 1'b1;
        tbl[16].d     = 8'hEE;
        tbl[16].r     = 1'b0;
        tbl[16].e_cnt = 16;
        tbl[16].e_rts = 1'b1;
        tbl[16].e_rdy = 1'b0;
        tbl[16].e_ovf = 1'b1;

        model_reset();
        rst_ni = 1'b0;
        #12;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_state("reset");
        chk("reset.data", 32'(data_o), 32'h0);

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            chk("tbl.count", 32'(count_o), 32'(tbl[i].e_cnt));
            chk("tbl.rts", 32'(rts_o), 32'(tbl[i].e_rts));
            chk("tbl.ready", 32'(ready_o), 32'(tbl[i].e_rdy));
            chk("tbl.ovf", 32'(overflow_o), 32'(tbl[i].e_ovf));
        end
        chk("tbl.drop", 32'(drop_count_o), STATS ? 32'd1 : 32'd0);

        // Drain from full: 0x01..0x10 in order, rts drops at count 8
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            if (i == 6) chk("drain.rts_at9", 32'(rts_o), 32'd1);
            if (i == 7) chk("drain.rts_at8", 32'(rts_o), 32'd0);
        end
        chk("drain.valid_end", 32'(valid_o), 32'd0);
        chk("drain.ovf_sticky", 32'(overflow_o), 32'd1);

        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clear1.ovf", 32'(overflow_o), 32'd0);

        // Continuous stream: one beat in and out per cycle
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
            if (i == 0) chk("stream.first_valid", 32'(valid_o), 32'd1);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Hover between the marks
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        chk("hover.rts_at12", 32'(rts_o), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 8'(8'hA0 + 2 * k), 1'b0, 1'b0);
            cycle(1'b1, 8'(8'hA1 + 2 * k), 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("hover.rts_at9", 32'(rts_o), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("hover.rts_at8", 32'(rts_o), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        chk("hover.rts_at11", 32'(rts_o), 32'd0);
        chk("hover.count11", 32'(count_o), 32'd11);

        // Clear at count 10 with a simultaneous push and pop
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("clear.pre_count", 32'(count_o), 32'd10);
        cycle(1'b1, 8'hAA, 1'b1, 1'b1);
        chk("clear.count", 32'(count_o), 32'd0);
        chk("clear.valid", 32'(valid_o), 32'd0);
        chk("clear.rts", 32'(rts_o), 32'd0);
        chk("clear.ovf", 32'(overflow_o), 32'd0);
        cycle(1'b1, 8'h31, 1'b0, 1'b0);
        cycle(1'b1, 8'h32, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("clear.sb_empty", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset mid-stream at count 7
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h51 + i), 1'b0, 1'b0);
        chk("areset.pre_count", 32'(count_o), 32'd7);
        valid_i = 1'b1;
        data_i  = 8'h77;
        #3;
        rst_ni = 1'b0;
        #1;
        chk("areset.count", 32'(count_o), 32'd0);
        chk("areset.valid", 32'(valid_o), 32'd0);
        chk("areset.ready", 32'(ready_o), 32'd1);
        chk("areset.rts", 32'(rts_o), 32'd0);
        chk("areset.ovf", 32'(overflow_o), 32'd0);
        chk("areset.data", 32'(data_o), 32'h0);
        chk("areset.drop", 32'(drop_count_o), 32'h0);
        valid_i = 1'b0;
        model_reset();
        #2;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_state("post_reset");

        // Pointer-wrap run: 3*Depth beats with random stalls on both sides
        n_pushed = 0;
        for (int c = 0; c < 500 && n_pushed < 3 * D; c++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            if (v && m_cnt != D) n_pushed++;
            cycle(v, 8'($urandom_range(0, 255)), r, 1'b0);
        end
        chk("wrap.progress", 32'(n_pushed), 32'(3 * D));
        for (int c = 0; c < 40 && m_cnt != 0; c++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap.drained", 32'(sb_q.size()), 32'd0);
        chk("wrap.valid_end", 32'(valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flow_fifo.md
# flow_fifo

Parametrised receive-path FIFO with hysteretic hardware flow control, intended to sit between the UART receiver and the image/command pipeline. It generalises the earlier single-threshold buffer with separate assert/deassert watermarks, an occupancy output, a synchronous flush, and sticky overflow reporting. All outputs are registered or decoded from registers only, so there is no combinational path from input to output.

## Interface
- Width, 8: data bits per beat.
- Depth, 16: total entries. Must be a power of two and at least 4.
- HighMark, 12: occupancy at which rts_o asserts.
- LowMark, 8: occupancy at which rts_o deasserts. Elaboration error unless LowMark < HighMark <= Depth.
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- clear_i  input  1  synchronous flush.
- data_i  input  Width  write data.
- valid_i  input  1  write request.
- ready_o  output  1  space available; not dependent on ready_i.
- data_o  output  Width  head data; stable while valid_o && !ready_i.
- valid_o  output  1  head valid.
- ready_i  input  1  consumer accepts.
- rts_o  output  1  high = stop sender (hysteretic).
- count_o  output  $clog2(Depth)+1  current occupancy, 0..Depth.
- overflow_o  output  1  sticky: a beat was offered while full.
- drop_count_o  output  16  rejected-beat count (see Configuration).

## Operation
- push = valid_i && ready_o; pop = valid_o && ready_i.
- Storage: the RAM and the output head register together hold Depth entries. count_o includes the head register.
- ready_o = (count != Depth). It is decoded from count only, so a full FIFO does not accept a beat in the same cycle as a pop.
- valid_o = (count != 0). The head register refills from the RAM after a pop, or directly from data_i when the FIFO is empty, so throughput stays at 1 beat/cycle.
- Pointers are $clog2(Depth)+1 bits and wrap naturally. Occupancy is the difference of write and read pointers, modulo 2^(AddrWidth+1).
- Push and pop in the same cycle: count unchanged, data order preserved.
- rts_o state machine, registered:
  - FLOW (rts_o=0) -> STOP when next count >= HighMark.
  - STOP (rts_o=1) -> FLOW when next count <= LowMark.
  - Counts between the marks hold the current state.
- Overflow: valid_i && !ready_o sets overflow_o. The beat is discarded and storage is unchanged.
- clear_i has priority over push and pop. Next cycle:
  - count_o=0, valid_o=0, ready_o=1;
  - rts_o=0 (FLOW), overflow_o=0, drop_count_o=0.
  - Any push in the clear cycle is discarded.
- Reset (rst_ni low, any time including mid-transfer) forces the same state as clear, asynchronously. data_o resets to 0.

## Timing
- Write-to-read latency: a beat pushed in cycle N into an empty FIFO gives valid_o=1 with that data in cycle N+1.
- count_o, ready_o, rts_o and overflow_o update in the cycle after the causing edge.
- rts_o reflects the post-update count in the same cycle as count_o, so it asserts the cycle after the push that reaches HighMark.
- Once full, ready_o returns high the cycle after a pop.
- Back-to-back push/pop streams at 1 beat/cycle with no bubbles once the FIFO is non-empty.

## Configuration
- FLOW_FIFO_STATS_EN defined:
  - drop_count_o increments on every rejected beat (valid_i && !ready_o).
  - It saturates at 16'hFFFF and clears on reset or clear_i.
- FLOW_FIFO_STATS_EN undefined: drop_count_o is tied to 0 and no counter logic is generated. overflow_o behaves identically in both builds.

## Test plan
- Default params, reset, push 0x01..0x10 with ready_i=0:
  - rts_o rises the cycle after the 12th push.
  - ready_o falls after the 16th push; count_o=16.
  - A 17th valid_i sets overflow_o; with STATS, drop_count_o=1.
- From full, ready_i=1 and no pushes:
  - data_o reads 0x01..0x10 in order.
  - rts_o stays high until count_o=8, then drops.
  - valid_o falls after the 16th pop.
- Continuous push and pop from count 0 for 100 beats:
  - first valid_o one cycle after the first push;
  - 1 beat/cycle, count_o never above 1, data matches input order.
- Hover test: fill to 12 (rts_o=1), alternate pop/push between counts 9 and 11; rts_o stays 1. Pop to 8 -> rts_o=0. Push back to 11 -> rts_o stays 0.
- At count 10, assert clear_i with valid_i=1 and ready_i=1 -> next cycle count_o=0, valid_o=0, rts_o=0, overflow_o=0; the pushed beat is not later output.
- Drop rst_ni asynchronously mid-stream at count 7 -> outputs reach reset values before the next clock edge. After release, a pointer-wrap run (3*Depth beats) is data-correct.
